alu_unit: RTL and testbench
===========================

Name: alu_unit

Overview:
- Parameterised two-operand integer ALU for the LEGv8-style single-cycle datapath. Sits in the execute stage.
- Result and zero outputs are purely combinational (zero latency).
- A synchronous NZCV condition-flag register is updated on request; it serves flag-setting instructions (ADDS/SUBS/ANDS) and conditional branches.

Parameters:
- N, 64, operand/result width in bits (must be >= 2)

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  synchronous active-high reset; clears flag register only
- a  input  N  operand A
- b  input  N  operand B
- ALUControl  input  4  operation select
- set_flags  input  1  when high at rising clk edge, flag register captures current N/Z/C/V
- result  output  N  combinational operation result
- zero  output  1  combinational; 1 iff result == 0
- flags  output  4  registered {N,Z,C,V}, bit 3 = N, bit 0 = V

Behaviour:
- ALUControl encoding:
  - 4'b0000 AND: a & b
  - 4'b0001 OR: a | b
  - 4'b0010 ADD: a + b, modulo 2^N
  - 4'b0110 SUB: a - b, computed as a + ~b + 1, modulo 2^N
  - 4'b0111 PASS_B: b
  - 4'b1100 NOR: ~(a | b)
  - any other code: result = 0, so zero = 1
- zero = ~|result for every code, including undefined codes.
- Next-flag values, combinational:
  - Nn = result[N-1]
  - Zn = zero
  - ADD: Cn = carry out of bit N-1; Vn = (a[N-1] == b[N-1]) && (result[N-1] != a[N-1])
  - SUB: Cn = carry out of a + ~b + 1 (1 means no borrow, i.e. a >= b unsigned); Vn = (a[N-1] != b[N-1]) && (result[N-1] != a[N-1])
  - all other ops: Cn = 0, Vn = 0
- Flag register, on rising edge of clk:
  - reset = 1 -> flags <= 4'b0000 (reset has priority over set_flags)
  - else set_flags = 1 -> flags <= {Nn,Zn,Cn,Vn}
  - else hold
- reset and set_flags never affect result or zero; these outputs follow the inputs combinationally at all times, including during reset.
- No X propagation from undefined codes; all outputs are fully defined for every input combination.
- Wrap-around:
  - ADD of 2^N-1 + 1 gives result 0, zero = 1, C = 1.
  - SUB of 0 - 1 gives all-ones, C = 0.

Optional Feature:
- Macro: ALU_SHIFT_EN
- Defined:
  - 4'b1000 = LSL: a << b[5:0] (shift amount uses low clog2(N) bits of b)
  - 4'b1001 = LSR: logical shift a >> b[5:0]
  - For both shifts: C = 0, V = 0; N and Z follow result as usual.
- Not defined: 4'b1000 and 4'b1001 behave as undefined codes (result 0, zero 1).

Decomposition:
- Package alu_pkg holds:
  - alu_op_e enum (4-bit) with ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASSB, ALU_NOR, ALU_LSL, ALU_LSR
  - flag bit-index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- One sub-module, alu_addsub: N-bit adder with invert-b/carry-in control producing sum, carry out and overflow. It is shared by ADD and SUB.
- The remaining logic (op mux and flag register) lives in alu_unit.

Test Plan (N=64):
- ADD: a=0000_0000_0000_0005, b=0000_0000_0000_0003, op 0010 -> result 0000_0000_0000_0008, zero 0; set_flags=1 -> flags 0000 next edge.
- SUB equal operands: a=b=1234_5678_9ABC_DEF0, op 0110 -> result 0, zero 1; set_flags -> flags 0110 (Z=1, C=1).
- Overflow/wrap:
  - ADD a=7FFF_FFFF_FFFF_FFFF, b=1 -> result 8000_0000_0000_0000, flags 1001 (N, V).
  - ADD a=FFFF_FFFF_FFFF_FFFF, b=1 -> result 0, zero 1, flags 0110.
- Logic ops: a=F0F0_F0F0_F0F0_F0F0, b=0F0F_0F0F_0F0F_0F0F:
  - AND -> 0, zero 1
  - OR -> FFFF_FFFF_FFFF_FFFF
  - NOR -> 0, zero 1
  - PASS_B -> b
- Undefined op 4'b1111 with a=b=FFFF_FFFF_FFFF_FFFF -> result 0, zero 1. With ALU_SHIFT_EN: a=1, b=3, op 1000 -> result 8; op 1001 with a=8, b=3 -> result 1.
- Reset/flag control:
  - Set flags to 1001, then assert reset together with set_flags=1 -> flags 0000 after the edge.
  - set_flags=0 while the op changes -> flags hold.
  - result stays combinational throughout reset.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes and flag bit positions for the execute-stage ALU.
// Shift opcodes are only decoded when ALU_SHIFT_EN is defined.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111,
    ALU_LSL   = 4'b1000,
    ALU_LSR   = 4'b1001,
    ALU_NOR   = 4'b1100
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_addsub.sv
// Shared N-bit adder: i_sub inverts b and injects a carry-in,
// so one carry chain serves both ADD and SUB.
module alu_addsub #(
  parameter int N = 64
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_sub,
  output logic [N-1:0] o_sum,
  output logic         o_cout,
  output logic         o_ovf
);

  logic [N-1:0] w_bx;
  logic [N:0]   w_full;

  assign w_bx   = i_sub ? ~i_b : i_b;
  assign w_full = {1'b0, i_a} + {1'b0, w_bx}
                + {{N{1'b0}}, i_sub};
  assign o_sum  = w_full[N-1:0];
  assign o_cout = w_full[N];

  // Signed overflow: operands agree in sign, sum disagrees.
  assign o_ovf = (i_a[N-1] == w_bx[N-1])
               & (o_sum[N-1] != i_a[N-1]);

endmodule

// File: rtl/alu_unit.sv
// Execute-stage ALU: combinational result/zero plus NZCV flag register.
// Define ALU_SHIFT_EN to enable the LSL/LSR opcodes.
module alu_unit
  import alu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  input  logic         set_flags,
  output logic [N-1:0] result,
  output logic         zero,
  output logic [3:0]   flags
);

`ifdef ALU_SHIFT_EN
  localparam int SW = $clog2(N);
`endif

  logic         w_op_and;
  logic         w_op_or;
  logic         w_op_add;
  logic         w_op_sub;
  logic         w_op_passb;
  logic         w_op_nor;
  logic         w_op_lsl;
  logic         w_op_lsr;
  logic [N-1:0] w_sum;
  logic         w_cout;
  logic         w_ovf;
  logic [N-1:0] w_res;
  logic [3:0]   w_nzcv;
  logic         w_arith;
  logic [3:0]   r_flags;

  assign w_op_and   = (ALUControl == ALU_AND);
  assign w_op_or    = (ALUControl == ALU_OR);
  assign w_op_add   = (ALUControl == ALU_ADD);
  assign w_op_sub   = (ALUControl == ALU_SUB);
  assign w_op_passb = (ALUControl == ALU_PASSB);
  assign w_op_nor   = (ALUControl == ALU_NOR);
`ifdef ALU_SHIFT_EN
  assign w_op_lsl   = (ALUControl == ALU_LSL);
  assign w_op_lsr   = (ALUControl == ALU_LSR);
`else
  assign w_op_lsl   = 1'b0;
  assign w_op_lsr   = 1'b0;
`endif

  alu_addsub #(
    .N (N)
  ) u_addsub (
    .i_a    (a),
    .i_b    (b),
    .i_sub  (w_op_sub),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_ovf  (w_ovf)
  );

  always_comb begin
    w_res = '0;
    unique case (1'b1)
      w_op_and:   w_res = a & b;
      w_op_or:    w_res = a | b;
      w_op_add:   w_res = w_sum;
      w_op_sub:   w_res = w_sum;
      w_op_passb: w_res = b;
      w_op_nor:   w_res = ~(a | b);
`ifdef ALU_SHIFT_EN
      w_op_lsl:   w_res = a << b[SW-1:0];
      w_op_lsr:   w_res = a >> b[SW-1:0];
`endif
      default:    w_res = '0;
    endcase
  end

  assign result  = w_res;
  assign zero    = ~|w_res;
  assign w_arith = w_op_add | w_op_sub;

  always_comb begin
    w_nzcv         = '0;
    w_nzcv[FLAG_N] = w_res[N-1];
    w_nzcv[FLAG_Z] = zero;
    w_nzcv[FLAG_C] = w_arith & w_cout;
    w_nzcv[FLAG_V] = w_arith & w_ovf;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else if (set_flags) begin
      r_flags <= w_nzcv;
    end
  end

  assign flags = r_flags;

endmodule

// File: tb/tb_alu_unit.sv
// Directed plus randomized checks of alu_unit against an arithmetic model.
// Shift opcodes are expected live only when ALU_SHIFT_EN is defined.
module tb_alu_unit;

  logic        clk;
  logic        reset;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  op;
  logic        set_flags;
  logic [63:0] result;
  logic        zero;
  logic [3:0]  flags;

  int n_pass;
  int n_total;
  logic [3:0] mdl_flags;

  alu_unit #(.N(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .ALUControl (op),
    .set_flags  (set_flags),
    .result     (result),
    .zero       (zero),
    .flags      (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: plain unsigned/signed arithmetic on 64-bit values.
  function automatic void model(input logic [3:0] o,
                                input logic [63:0] x,
                                input logic [63:0] y,
                                output logic [63:0] r,
                                output logic [3:0] f);
    logic c;
    logic v;
    logic [64:0] wide;
    c = 1'b0;
    v = 1'b0;
    case (o)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: begin
        wide = {1'b0, x} + {1'b0, y};
        r = wide[63:0];
        c = wide[64];
        v = (x[63] == y[63]) && (r[63] != x[63]);
      end
      4'b0110: begin
        r = x - y;
        c = (x >= y);
        v = (x[63] != y[63]) && (r[63] != x[63]);
      end
      4'b0111: r = y;
      4'b1100: r = ~(x | y);
`ifdef ALU_SHIFT_EN
      4'b1000: r = x << y[5:0];
      4'b1001: r = x >> y[5:0];
`endif
      default: r = 64'd0;
    endcase
    f = {r[63], (r == 64'd0), c, v};
  endfunction

  task automatic apply(input logic [3:0] o,
                       input logic [63:0] x,
                       input logic [63:0] y,
                       input logic sf,
                       input logic rst);
    logic [63:0] er;
    logic [3:0]  ef;
    op        = o;
    a         = x;
    b         = y;
    set_flags = sf;
    reset     = rst;
    #1;
    model(o, x, y, er, ef);
    check("m_result", result, er);
    check("m_zero", {63'd0, zero}, {63'd0, ef[2]});
  endtask

  task automatic tick();
    logic [63:0] er;
    logic [3:0]  ef;
    model(op, a, b, er, ef);
    @(posedge clk);
    if (reset) mdl_flags = 4'b0000;
    else if (set_flags) mdl_flags = ef;
    #1;
    check("m_flags", {60'd0, flags}, {60'd0, mdl_flags});
  endtask

  logic [3:0]  ops [12];
  logic [63:0] edges [6];

  initial begin
    n_pass    = 0;
    n_total   = 0;
    mdl_flags = 4'b0000;
    ops   = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC,
              4'h8, 4'h9, 4'hF, 4'h3, 4'h2, 4'h6};
    edges = '{64'd0, 64'd1, '1, 64'h7FFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 64'd63};
    op = 4'h0; a = '0; b = '0; set_flags = 1'b0; reset = 1'b1;
    #1;

    // Reset clears flags; result stays combinational during reset.
    apply(4'b0010, 64'd5, 64'd3, 1'b1, 1'b1);
    check("rst_result", result, 64'd8);
    tick();
    check("rst_flags", {60'd0, flags}, 64'd0);

    apply(4'b0010, 64'd5, 64'd3, 1'b1, 1'b0);
    check("add_res", result, 64'd8);
    check("add_zero", {63'd0, zero}, 64'd0);
    tick();
    check("add_flags", {60'd0, flags}, 64'h0);

    apply(4'b0110, 64'h1234_5678_9ABC_DEF0,
          64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
    check("subeq_res", result, 64'd0);
    check("subeq_zero", {63'd0, zero}, 64'd1);
    tick();
    check("subeq_flags", {60'd0, flags}, 64'h6);

    apply(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0);
    check("ovf_res", result, 64'h8000_0000_0000_0000);
    tick();
    check("ovf_flags", {60'd0, flags}, 64'h9);

    apply(4'b0010, '1, 64'd1, 1'b1, 1'b0);
    check("wrap_res", result, 64'd0);
    check("wrap_zero", {63'd0, zero}, 64'd1);
    tick();
    check("wrap_flags", {60'd0, flags}, 64'h6);

    apply(4'b0110, 64'd0, 64'd1, 1'b1, 1'b0);
    check("sub01_res", result, '1);
    tick();
    check("sub01_flags", {60'd0, flags}, 64'h8);

    // Logic ops with set_flags low: flags must hold at 1000.
    apply(4'b0000, 64'hF0F0_F0F0_F0F0_F0F0,
          64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0);
    check("and_res", result, 64'd0);
    check("and_zero", {63'd0, zero}, 64'd1);
    tick();
    apply(4'b0001, 64'hF0F0_F0F0_F0F0_F0F0,
          64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0);
    check("or_res", result, '1);
    tick();
    apply(4'b1100, 64'hF0F0_F0F0_F0F0_F0F0,
          64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0);
    check("nor_res", result, 64'd0);
    check("nor_zero", {63'd0, zero}, 64'd1);
    tick();
    apply(4'b0111, 64'hF0F0_F0F0_F0F0_F0F0,
          64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0);
    check("passb_res", result, 64'h0F0F_0F0F_0F0F_0F0F);
    tick();
    check("hold_flags", {60'd0, flags}, 64'h8);

    apply(4'b1111, '1, '1, 1'b0, 1'b0);
    check("undef_res", result, 64'd0);
    check("undef_zero", {63'd0, zero}, 64'd1);
    apply(4'b1000, 64'd1, 64'd3, 1'b0, 1'b0);
`ifdef ALU_SHIFT_EN
    check("lsl_res", result, 64'd8);
    apply(4'b1001, 64'd8, 64'd3, 1'b0, 1'b0);
    check("lsr_res", result, 64'd1);
`else
    check("lsl_undef", result, 64'd0);
    apply(4'b1001, 64'd8, 64'd3, 1'b0, 1'b0);
    check("lsr_undef", result, 64'd0);
`endif
    tick();

    // Reset wins over set_flags.
    apply(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0);
    tick();
    check("pre_rst_flags", {60'd0, flags}, 64'h9);
    apply(4'b0110, 64'd0, 64'd1, 1'b1, 1'b1);
    check("rst_comb_res", result, '1);
    tick();
    check("rst_prio_flags", {60'd0, flags}, 64'h0);

    for (int i = 0; i < 300; i++) begin
      logic [63:0] x;
      logic [63:0] y;
      x = {$urandom(), $urandom()};
      y = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) x = edges[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) y = edges[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) y = x;
      apply(ops[$urandom_range(0, 11)], x, y,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
